// File: rtl/systolic_mm_pkg.sv
// Shared types and helpers for the systolic matrix-multiply engine.
// SYSTOLIC_MM_SAT_EN selects saturating accumulation in the engine; sat_add serves that build.
package systolic_mm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN,
    DONE
  } state_t;

  // The last operand pair lands in the far corner 2*(dim-1) advances after its beat.
  function automatic int drain_cycles(input int dim);
    return 2 * dim - 1;
  endfunction

  // Signed add clamped to the range of a 'bits'-wide two's complement value.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int bits);
    logic signed [64:0] sum;
    logic signed [64:0] max_v;
    logic signed [64:0] min_v;
    sum   = {a[63], a} + {b[63], b};
    max_v = (65'sd1 <<< (bits - 1)) - 65'sd1;
    min_v = -max_v - 65'sd1;
    if (sum > max_v) return max_v[63:0];
    if (sum < min_v) return min_v[63:0];
    return sum[63:0];
  endfunction

endpackage

// File: rtl/systolic_mm_skew_line.sv
// Enable-gated delay line that staggers one operand lane into the array.
// DEPTH=0 degenerates to a plain wire.
module systolic_skew_line #(
  parameter int W     = 32,
  parameter int DEPTH = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ok;
    assign unused_ok = ^{clk, rst, en};
    assign q = d;
  end else begin : g_shift
    logic [W-1:0] sr_q [DEPTH];

    // NOTE: non-blocking assignments make every stage sample the pre-edge value of its neighbour.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
      end else if (en) begin
        sr_q[0] <= d;
        for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
      end
    end

    assign q = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/systolic_mm_engine.sv
// Output-stationary DIMxDIM systolic engine computing C += A*B over k_len beats.
// Define SYSTOLIC_MM_SAT_EN for saturating accumulation; default build wraps.
module systolic_mm_engine
  import systolic_mm_pkg::*;
#(
  parameter int BITS_AB   = 32,
  parameter int BITS_C    = 32,
  parameter int DIM       = 8,
  parameter int OUT_LANES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         clear_acc,
  input  logic [15:0]                  k_len,
  output logic                         busy,
  output logic                         done,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DIM*BITS_AB-1:0]       a_vec,
  input  logic [DIM*BITS_AB-1:0]       b_vec,
  input  logic                         c_wr_en,
  input  logic [$clog2(DIM)-1:0]       c_wr_row,
  input  logic [DIM*BITS_C-1:0]        c_wr_data,
  input  logic                         c_rd_en,
  input  logic [$clog2(DIM)-1:0]       c_rd_row,
  input  logic [((DIM/OUT_LANES > 1) ? $clog2(DIM/OUT_LANES) : 1)-1:0] c_rd_chunk,
  output logic [OUT_LANES*BITS_C-1:0]  c_rd_data,
  output logic                         c_rd_valid
);

  localparam int CW      = $clog2(DIM);
  localparam int DRAIN_N = drain_cycles(DIM);
  localparam int DCW     = $clog2(DRAIN_N + 1);
  localparam int PW      = (2 * BITS_AB > BITS_C) ? 2 * BITS_AB : BITS_C;

  state_t         state_q, state_d;
  logic [15:0]    k_len_q, k_len_d;
  logic [15:0]    beat_cnt_q, beat_cnt_d;
  logic [DCW-1:0] drain_cnt_q, drain_cnt_d;

  logic           adv;
  logic           clr_all;
  logic [DIM-1:0] wr_sel;
  logic           rd_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      k_len_q     <= '0;
      beat_cnt_q  <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      beat_cnt_q  <= beat_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    k_len_d     = k_len_q;
    beat_cnt_d  = beat_cnt_q;
    drain_cnt_d = drain_cnt_q;
    busy        = (state_q != IDLE);
    done        = (state_q == DONE);
    in_ready    = (state_q == FEED);
    unique case (state_q)
      IDLE: if (start) begin
        k_len_d     = k_len;
        beat_cnt_d  = '0;
        drain_cnt_d = '0;
        state_d     = (k_len == 16'd0) ? DONE : FEED;
      end
      FEED: if (in_valid) begin
        if (beat_cnt_q == k_len_q - 16'd1) state_d = DRAIN;
        else beat_cnt_d = beat_cnt_q + 16'd1;
      end
      DRAIN: begin
        if (drain_cnt_q == DCW'(DRAIN_N - 1)) state_d = DONE;
        else drain_cnt_d = drain_cnt_q + DCW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Feed beats only advance on acceptance; drain clocks zeros through every cycle.
  assign adv     = ((state_q == FEED) && in_valid) || (state_q == DRAIN);
  assign clr_all = (state_q == IDLE) && start && clear_acc;
  assign wr_sel  = ((state_q == IDLE) && c_wr_en) ? (DIM'(1) << c_wr_row) : '0;
  assign rd_fire = (state_q == IDLE) && c_rd_en;

  logic signed [BITS_AB-1:0] feed_a [DIM];
  logic signed [BITS_AB-1:0] feed_b [DIM];
  logic signed [BITS_AB-1:0] a_sk   [DIM];
  logic signed [BITS_AB-1:0] b_sk   [DIM];

  always_comb begin
    for (int i = 0; i < DIM; i++) begin
      feed_a[i] = (state_q == FEED) ? a_vec[i*BITS_AB +: BITS_AB] : '0;
      feed_b[i] = (state_q == FEED) ? b_vec[i*BITS_AB +: BITS_AB] : '0;
    end
  end

  for (genvar i = 0; i < DIM; i++) begin : g_skew
    systolic_skew_line #(.W(BITS_AB), .DEPTH(i)) u_skew_a (
      .clk(clk), .rst(rst), .en(adv), .d(feed_a[i]), .q(a_sk[i])
    );
    systolic_skew_line #(.W(BITS_AB), .DEPTH(i)) u_skew_b (
      .clk(clk), .rst(rst), .en(adv), .d(feed_b[i]), .q(b_sk[i])
    );
  end

  logic signed [BITS_AB-1:0] a_out [DIM][DIM];
  logic signed [BITS_AB-1:0] b_out [DIM][DIM];
  logic [BITS_C-1:0]         acc_w [DIM][DIM];

  for (genvar r = 0; r < DIM; r++) begin : g_row
    for (genvar c = 0; c < DIM; c++) begin : g_col
      logic signed [BITS_AB-1:0]   a_in, b_in, a_q, b_q;
      logic signed [BITS_C-1:0]    acc_q, mac_sum;
      logic signed [2*BITS_AB-1:0] prod;
      logic signed [PW-1:0]        prod_x;

      if (c == 0) begin : g_a_edge
        assign a_in = a_sk[r];
      end else begin : g_a_link
        assign a_in = a_out[r][c-1];
      end
      if (r == 0) begin : g_b_edge
        assign b_in = b_sk[c];
      end else begin : g_b_link
        assign b_in = b_out[r-1][c];
      end

      assign prod   = a_in * b_in;
      assign prod_x = prod;
`ifdef SYSTOLIC_MM_SAT_EN
      logic signed [63:0] acc_x, prod_w, sum_sat;
      assign acc_x   = acc_q;
      assign prod_w  = prod;
      assign sum_sat = sat_add(acc_x, prod_w, BITS_C);
      assign mac_sum = sum_sat[BITS_C-1:0];
`else
      assign mac_sum = acc_q + prod_x[BITS_C-1:0];
`endif

      // NOTE: accumulators are reset explicitly; an aborted run must leave C all zero.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q   <= '0;
          b_q   <= '0;
          acc_q <= '0;
        end else begin
          if (adv) begin
            a_q <= a_in;
            b_q <= b_in;
          end
          if (clr_all)        acc_q <= '0;
          else if (wr_sel[r]) acc_q <= c_wr_data[c*BITS_C +: BITS_C];
          else if (adv)       acc_q <= mac_sum;
        end
      end

      assign a_out[r][c] = a_q;
      assign b_out[r][c] = b_q;
      assign acc_w[r][c] = acc_q;
    end
  end

  logic [OUT_LANES*BITS_C-1:0] rd_mux;
  logic [OUT_LANES*BITS_C-1:0] rd_data_q;
  logic                        rd_valid_q;

  always_comb begin
    rd_mux = '0;
    for (int l = 0; l < OUT_LANES; l++)
      rd_mux[l*BITS_C +: BITS_C] = acc_w[c_rd_row][CW'(int'(c_rd_chunk) * OUT_LANES + l)];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_fire;
      if (rd_fire) rd_data_q <= rd_mux;
    end
  end

  assign c_rd_data  = rd_data_q;
  assign c_rd_valid = rd_valid_q;

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Scoreboard bench for systolic_mm_engine: 4x4/16-bit instance plus a default-parameter instance.
module tb_systolic_mm_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, clear_acc, in_valid, c_wr_en, c_rd_en;
  logic [15:0] k_len;
  logic        busy, done, in_ready, c_rd_valid;
  logic [63:0] a_vec, b_vec, c_wr_data;
  logic [1:0]  c_wr_row, c_rd_row;
  logic [0:0]  c_rd_chunk;
  logic [31:0] c_rd_data;

  logic         b_start, b_clear, b_in_valid, b_wr_en, b_rd_en;
  logic [15:0]  b_klen;
  logic         b_busy, b_done, b_in_ready, b_rd_valid;
  logic [255:0] b_a_vec, b_b_vec, b_wr_data;
  logic [2:0]   b_wr_row, b_rd_row;
  logic [0:0]   b_rd_chunk;
  logic [127:0] b_rd_data;

  always #5 clk = ~clk;

  systolic_mm_engine #(.BITS_AB(16), .BITS_C(16), .DIM(4), .OUT_LANES(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .clear_acc(clear_acc), .k_len(k_len),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
    .a_vec(a_vec), .b_vec(b_vec), .c_wr_en(c_wr_en), .c_wr_row(c_wr_row),
    .c_wr_data(c_wr_data), .c_rd_en(c_rd_en), .c_rd_row(c_rd_row),
    .c_rd_chunk(c_rd_chunk), .c_rd_data(c_rd_data), .c_rd_valid(c_rd_valid)
  );

  systolic_mm_engine u_big (
    .clk(clk), .rst(rst), .start(b_start), .clear_acc(b_clear), .k_len(b_klen),
    .busy(b_busy), .done(b_done), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .a_vec(b_a_vec), .b_vec(b_b_vec), .c_wr_en(b_wr_en), .c_wr_row(b_wr_row),
    .c_wr_data(b_wr_data), .c_rd_en(b_rd_en), .c_rd_row(b_rd_row),
    .c_rd_chunk(b_rd_chunk), .c_rd_data(b_rd_data), .c_rd_valid(b_rd_valid)
  );

  int checks = 0;
  int errors = 0;

  logic signed [15:0] am [4][4];
  logic signed [15:0] bm [4][4];
  logic [15:0]        cm [4][4];
  logic [31:0]        exp_q [$];
  logic [127:0]       exp_big_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic logic [63:0] pack_a(input int k);
    logic [63:0] v;
    for (int r = 0; r < 4; r++) v[r*16 +: 16] = am[r][k];
    return v;
  endfunction

  function automatic logic [63:0] pack_b(input int k);
    logic [63:0] v;
    for (int c = 0; c < 4; c++) v[c*16 +: 16] = bm[k][c];
    return v;
  endfunction

  task automatic model_mm(input int k_n, input logic clr);
    longint p;
    longint s;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        if (clr) cm[r][c] = '0;
        for (int k = 0; k < k_n; k++) begin
          p = longint'(am[r][k]) * longint'(bm[k][c]);
`ifdef SYSTOLIC_MM_SAT_EN
          s = longint'($signed(cm[r][c])) + p;
          if (s > 32767) s = 32767;
          else if (s < -32768) s = -32768;
          cm[r][c] = s[15:0];
`else
          s = p;
          cm[r][c] = cm[r][c] + s[15:0];
`endif
        end
      end
  endtask

  task automatic read_chunk(input int row, input int chunk, input string name);
    logic [31:0] want;
    int n;
    exp_q.push_back({cm[row][2*chunk+1], cm[row][2*chunk]});
    c_rd_en = 1'b1;
    c_rd_row = row[1:0];
    c_rd_chunk = chunk[0:0];
    tick();
    c_rd_en = 1'b0;
    n = 0;
    while (!c_rd_valid && n < 4) begin
      tick();
      n++;
    end
    want = exp_q.pop_front();
    checks++;
    if (!c_rd_valid) begin
      errors++;
      $display("FAIL %s r%0d ch%0d: no c_rd_valid, expected data %0h", name, row, chunk, want);
    end else if (c_rd_data !== want) begin
      errors++;
      $display("FAIL %s r%0d ch%0d: got %0h expected %0h", name, row, chunk, c_rd_data, want);
    end
  endtask

  task automatic read_all(input string name);
    for (int r = 0; r < 4; r++)
      for (int ch = 0; ch < 2; ch++) read_chunk(r, ch, name);
  endtask

  task automatic write_row(input int row, input logic [15:0] val);
    c_wr_en = 1'b1;
    c_wr_row = row[1:0];
    c_wr_data = {4{val}};
    tick();
    c_wr_en = 1'b0;
    for (int c = 0; c < 4; c++) cm[row][c] = val;
  endtask

  task automatic run_mm(input int k_n, input logic clr, input int stall_n, output int cyc);
    int slots, cnt, beat, idx;
    logic [15:0] mask;
    model_mm(k_n, clr);
    start = 1'b1;
    clear_acc = clr;
    k_len = 16'(k_n);
    tick();
    start = 1'b0;
    clear_acc = 1'b0;
    cyc = 0;
    if (k_n > 0) begin
      chk("in_ready_in_feed", {31'd0, in_ready}, 32'd1);
      slots = k_n + stall_n;
      mask = '0;
      cnt = 0;
      while (cnt < stall_n) begin
        idx = $urandom_range(0, slots - 1);
        if (!mask[idx]) begin
          mask[idx] = 1'b1;
          cnt++;
        end
      end
      beat = 0;
      for (int s = 0; s < slots; s++) begin
        if (mask[s]) begin
          in_valid = 1'b0;
          a_vec = {$urandom(), $urandom()};
          b_vec = {$urandom(), $urandom()};
        end else begin
          in_valid = 1'b1;
          a_vec = pack_a(beat);
          b_vec = pack_b(beat);
          beat++;
        end
        tick();
        cyc++;
      end
      in_valid = 1'b0;
      a_vec = '0;
      b_vec = '0;
    end
    while (!done && cyc < 200) begin
      tick();
      cyc++;
    end
    tick();
    chk("done_one_cycle", {30'd0, done, busy}, 32'd0);
  endtask

  task automatic test_reset();
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
    chk("reset_rd_valid", {31'd0, c_rd_valid}, 32'd0);
    chk("reset_rd_data", c_rd_data, 32'd0);
    read_chunk(0, 0, "reset_read");
    read_chunk(3, 1, "reset_read");
  endtask

  task automatic set_identity();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        am[i][j] = (i == j) ? 16'sd1 : 16'sd0;
        bm[i][j] = 16'(i * 4 + j);
      end
  endtask

  task automatic test_identity();
    int cyc;
    set_identity();
    run_mm(4, 1'b1, 0, cyc);
    chk("identity_latency", cyc, 32'd11);
    read_all("identity");
  endtask

  task automatic test_stall();
    int cyc;
    write_row(2, 16'h1234);
    set_identity();
    run_mm(4, 1'b1, 3, cyc);
    chk("stall_latency", cyc, 32'd14);
    read_all("stall");
  endtask

  task automatic test_accumulate();
    int cyc;
    for (int r = 0; r < 4; r++) write_row(r, 16'd5);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        am[i][j] = 16'sd1;
        bm[i][j] = 16'sd1;
      end
    run_mm(4, 1'b0, 0, cyc);
    chk("acc_9_value", {16'd0, cm[1][2]}, 32'd9);
    read_all("accumulate");
  endtask

  task automatic test_overflow();
    int cyc;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        am[i][j] = 16'sh7FFF;
        bm[i][j] = 16'sh7FFF;
      end
    run_mm(2, 1'b1, 0, cyc);
`ifdef SYSTOLIC_MM_SAT_EN
    chk("overflow_model", {16'd0, cm[0][0]}, 32'h7FFF);
`else
    chk("overflow_model", {16'd0, cm[0][0]}, 32'h0002);
`endif
    read_all("overflow");
  endtask

  task automatic test_klen_zero_and_ignore();
    int cyc;
    run_mm(0, 1'b0, 0, cyc);
    chk("klen0_latency", cyc, 32'd0);
    read_chunk(2, 1, "klen0_unchanged");
    for (int i = 0; i < 4; i++) begin
      am[i][0] = 16'sd0;
      bm[0][i] = 16'sd0;
    end
    start = 1'b1;
    k_len = 16'd1;
    tick();
    c_rd_en = 1'b1;
    c_wr_en = 1'b1;
    c_wr_row = 2'd0;
    c_wr_data = {4{16'hAAAA}};
    tick();
    start = 1'b0;
    c_rd_en = 1'b0;
    c_wr_en = 1'b0;
    chk("feed_rd_ignored", {31'd0, c_rd_valid}, 32'd0);
    chk("feed_start_ignored", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    a_vec = '0;
    b_vec = '0;
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (!done && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("feed_done_seen", {31'd0, done}, 32'd1);
    tick();
    tick();
    chk("no_requeued_start", {31'd0, busy}, 32'd0);
    read_chunk(0, 0, "feed_wr_ignored");
  endtask

  task automatic test_preload_clear_priority();
    c_wr_en = 1'b1;
    c_wr_row = 2'd3;
    c_wr_data = {4{16'hBEEF}};
    start = 1'b1;
    clear_acc = 1'b1;
    k_len = 16'd0;
    tick();
    c_wr_en = 1'b0;
    start = 1'b0;
    clear_acc = 1'b0;
    chk("prio_done", {31'd0, done}, 32'd1);
    tick();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) cm[r][c] = '0;
    read_chunk(3, 0, "prio_clear");
    read_chunk(0, 1, "prio_clear");
  endtask

  task automatic test_reset_in_drain();
    int seen;
    for (int r = 0; r < 4; r++) write_row(r, 16'd7);
    start = 1'b1;
    k_len = 16'd2;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    a_vec = {4{16'd3}};
    b_vec = {4{16'd4}};
    tick();
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("drain_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) seen++;
      tick();
    end
    chk("rst_no_done", seen, 32'd0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) cm[r][c] = '0;
    read_all("rst_cleared");
  endtask

  task automatic test_default_params();
    int cyc;
    logic [127:0] want;
    b_start = 1'b1;
    b_clear = 1'b1;
    b_klen = 16'd1;
    tick();
    b_start = 1'b0;
    b_clear = 1'b0;
    b_in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b_a_vec[i*32 +: 32] = 32'hFFFF_FFFD;
      b_b_vec[i*32 +: 32] = 32'(i + 1);
    end
    tick();
    b_in_valid = 1'b0;
    cyc = 1;
    while (!b_done && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("big_latency", cyc, 32'd16);
    tick();
    for (int l = 0; l < 4; l++) want[l*32 +: 32] = 32'(-3 * (5 + l));
    exp_big_q.push_back(want);
    b_rd_en = 1'b1;
    b_rd_row = 3'd7;
    b_rd_chunk = 1'b1;
    tick();
    b_rd_en = 1'b0;
    want = exp_big_q.pop_front();
    checks++;
    if (!b_rd_valid || b_rd_data !== want) begin
      errors++;
      $display("FAIL big_read: valid %0b got %0h expected %0h", b_rd_valid, b_rd_data, want);
    end
  endtask

  initial begin
    rst = 1'b1;
    {start, clear_acc, in_valid, c_wr_en, c_rd_en} = '0;
    k_len = '0;
    a_vec = '0;
    b_vec = '0;
    c_wr_data = '0;
    c_wr_row = '0;
    c_rd_row = '0;
    c_rd_chunk = '0;
    {b_start, b_clear, b_in_valid, b_wr_en, b_rd_en} = '0;
    b_klen = '0;
    b_a_vec = '0;
    b_b_vec = '0;
    b_wr_data = '0;
    b_wr_row = '0;
    b_rd_row = '0;
    b_rd_chunk = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) cm[r][c] = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_identity();
    test_stall();
    test_accumulate();
    test_overflow();
    test_klen_zero_and_ignore();
    test_preload_clear_priority();
    test_reset_in_drain();
    test_default_params();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
